// File: rtl/nibble_serial_subtractor_if.sv
// Handshake and data bundle for the nibble-serial subtractor.
// The master side supplies operands and consumes results; the slave side is the subtractor.
interface nibble_serial_subtractor_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] SUB_1;
  logic [WIDTH-1:0] SUB_2;
  logic             B_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] D;
  logic             B_out;
  logic             OVF;

  modport master (
    output in_valid, SUB_1, SUB_2, B_in, out_ready,
    input  in_ready, out_valid, D, B_out, OVF
  );

  modport slave (
    input  in_valid, SUB_1, SUB_2, B_in, out_ready,
    output in_ready, out_valid, D, B_out, OVF
  );
endinterface

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle subtractor D = SUB_1 - SUB_2 - B_in, one NIB-bit slice per clock, LSB slice first.
// The difference is formed as SUB_1 + ~SUB_2 + ~B_in through one registered NIB-bit carry chain.
module nibble_serial_subtractor #(
  parameter int WIDTH = 16,
  parameter int NIB   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  nibble_serial_subtractor_if.slave   bus
);

  localparam int NNIB = WIDTH / NIB;
  localparam int CW   = (NNIB > 1) ? $clog2(NNIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NNIB - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] bn_q, bn_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             b_out_q, b_out_d;
  logic             ovf_q, ovf_d;

  logic [NIB-1:0]   a_nib_s;
  logic [NIB-1:0]   bn_nib_s;
  logic [NIB:0]     sum_s;

  // Current slice of the latched operands and its sum with the running carry.
  always_comb begin
    a_nib_s  = a_q[int'(cnt_q) * NIB +: NIB];
    bn_nib_s = bn_q[int'(cnt_q) * NIB +: NIB];
    sum_s    = {1'b0, a_nib_s} + {1'b0, bn_nib_s} + {{NIB{1'b0}}, carry_q};
  end

  // Next-state and datapath update for IDLE/RUN/DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    bn_d    = bn_q;
    d_d     = d_q;
    b_out_d = b_out_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.SUB_1;
          bn_d    = ~bus.SUB_2;
          carry_d = ~bus.B_in;
          cnt_d   = {CW{1'b0}};
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        d_d[int'(cnt_q) * NIB +: NIB] = sum_s[NIB-1:0];
        carry_d = sum_s[NIB];
        if (cnt_q == LAST) begin
          // Carry out of the top slice is the inverted borrow; the top sum bit is D's msb.
          b_out_d = ~sum_s[NIB];
          ovf_d   = (a_q[WIDTH-1] != ~bn_q[WIDTH-1]) && (sum_s[NIB-1] != a_q[WIDTH-1]);
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset that discards any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= {CW{1'b0}};
      carry_q <= 1'b0;
      a_q     <= {WIDTH{1'b0}};
      bn_q    <= {WIDTH{1'b0}};
      d_q     <= {WIDTH{1'b0}};
      b_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      bn_q    <= bn_d;
      d_q     <= d_d;
      b_out_q <= b_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.D         = d_q;
  assign bus.B_out     = b_out_q;
  assign bus.OVF       = ovf_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Self-checking bench: random and directed subtractions against a plain-arithmetic model,
// with per-cycle handshake/result comparison plus literal checks of specific cases.
module tb_nibble_serial_subtractor;

  localparam int W = 16;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  nibble_serial_subtractor_if #(.WIDTH(W)) bus ();

  nibble_serial_subtractor #(.WIDTH(W), .NIB(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // {OVF, B_out, D} from the arithmetic definition of the difference.
  function automatic logic [W+1:0] exp_of(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic bin);
    logic [W:0]   diff;
    logic         ovf;
    diff = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    ovf  = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
    return {ovf, diff[W], diff[W-1:0]};
  endfunction

  // Reference: cycles since accept (0 idle, 1..4 computing, 5 result held).
  int             m_phase;
  logic           m_dzero;
  logic           armed;
  logic [W+1:0]   m_exp;

  initial begin
    m_phase = 0;
    m_dzero = 1'b0;
    armed   = 1'b0;
    m_exp   = '0;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0;
      m_dzero <= 1'b1;
      armed   <= 1'b1;
    end else if (m_phase == 0) begin
      if (bus.in_valid) begin
        m_phase <= 1;
        m_exp   <= exp_of(bus.SUB_1, bus.SUB_2, bus.B_in);
        m_dzero <= 1'b0;
      end
    end else if (m_phase < 4) begin
      m_phase <= m_phase + 1;
    end else if (m_phase == 4) begin
      m_phase <= 5;
    end else if (bus.out_ready) begin
      m_phase <= 0;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("in_ready", 32'(bus.in_ready), 32'(m_phase == 0));
      chk("out_valid", 32'(bus.out_valid), 32'(m_phase == 5));
      if (m_phase == 5) begin
        chk("D", 32'(bus.D), 32'(m_exp[W-1:0]));
        chk("B_out", 32'(bus.B_out), 32'(m_exp[W]));
        chk("OVF", 32'(bus.OVF), 32'(m_exp[W+1]));
      end
      if (m_phase == 0 && m_dzero) begin
        chk("rst_D", 32'(bus.D), 32'h0);
        chk("rst_B_out", 32'(bus.B_out), 32'h0);
        chk("rst_OVF", 32'(bus.OVF), 32'h0);
      end
    end
  end

  // Issue one operation from idle; leaves the bench in DONE with out_ready=0.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    int n;
    bus.in_valid = 1'b1;
    bus.SUB_1    = a;
    bus.SUB_2    = b;
    bus.B_in     = bin;
    @(posedge clk);
    #2;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      bus.in_valid  = 1'($urandom);
      bus.SUB_1     = 16'($urandom);
      bus.SUB_2     = 16'($urandom);
      bus.B_in      = 1'($urandom);
      bus.out_ready = 1'($urandom);
      @(posedge clk);
      #2;
      n++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("latency", 32'(n), 32'd4);
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #2;
    bus.out_ready = 1'b0;
  endtask

  task automatic directed(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                          input logic [W-1:0] ed, input logic eb, input logic eo);
    issue(a, b, bin);
    chk("lit_D", 32'(bus.D), 32'(ed));
    chk("lit_B_out", 32'(bus.B_out), 32'(eb));
    chk("lit_OVF", 32'(bus.OVF), 32'(eo));
    release_result();
  endtask

  initial begin
    logic [W-1:0] held_d;
    logic         held_b;
    logic         held_o;
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.SUB_1     = '0;
    bus.SUB_2     = '0;
    bus.B_in      = 1'b0;
    bus.out_ready = 1'b0;

    chk("model_pin_a", 32'(exp_of(16'h8000, 16'h0001, 1'b0)), 32'({1'b1, 1'b0, 16'h7FFF}));
    chk("model_pin_b", 32'(exp_of(16'h0005, 16'h0005, 1'b1)), 32'({1'b0, 1'b1, 16'hFFFF}));

    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    rst = 1'b0;
    chk("reset_in_ready", 32'(bus.in_ready), 32'h1);
    chk("reset_out_valid", 32'(bus.out_valid), 32'h0);
    chk("reset_D", 32'(bus.D), 32'h0);

    directed(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
    directed(16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b0, 1'b0);
    directed(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    directed(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    directed(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
    directed(16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    directed(16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0);

    // Backpressure: result must hold while inputs churn.
    issue(16'h4321, 16'h1111, 1'b0);
    held_d = bus.D;
    held_b = bus.B_out;
    held_o = bus.OVF;
    chk("bp_lit_D", 32'(held_d), 32'h3210);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'($urandom);
      bus.SUB_1    = 16'($urandom);
      bus.SUB_2    = 16'($urandom);
      @(posedge clk);
      #2;
      chk("bp_hold_D", 32'(bus.D), 32'(held_d));
      chk("bp_hold_flags", 32'({bus.B_out, bus.OVF}), 32'({held_b, held_o}));
      chk("bp_in_ready", 32'(bus.in_ready), 32'h0);
    end
    bus.in_valid = 1'b0;
    release_result();
    chk("bp_release_in_ready", 32'(bus.in_ready), 32'h1);
    chk("bp_release_out_valid", 32'(bus.out_valid), 32'h0);
    directed(16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0);

    // Reset during the second computing cycle aborts the operation.
    bus.in_valid = 1'b1;
    bus.SUB_1    = 16'h9999;
    bus.SUB_2    = 16'h1234;
    bus.B_in     = 1'b0;
    @(posedge clk);
    #2;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    chk("abort_in_ready", 32'(bus.in_ready), 32'h1);
    chk("abort_out_valid", 32'(bus.out_valid), 32'h0);
    chk("abort_D", 32'(bus.D), 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #2;
      chk("abort_no_result", 32'(bus.out_valid), 32'h0);
    end
    directed(16'h0003, 16'h0002, 1'b0, 16'h0001, 1'b0, 1'b0);

    // Random operations with random idle gaps and random result backpressure.
    for (int i = 0; i < 200; i++) begin
      int gap;
      int hold;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        @(posedge clk);
        #2;
      end
      issue(16'($urandom), 16'($urandom), 1'($urandom));
      hold = int'($urandom_range(0, 3));
      for (int h = 0; h < hold; h++) begin
        @(posedge clk);
        #2;
      end
      release_result();
    end

    @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
